// File: rtl/simd_pass_sequencer.sv
// Issue sequencer for a 64-lane SIMD unit executed as four 16-lane passes:
// operand reads, ALU result strobes, optional scalar writeback, completion pulse.
module simd_pass_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    output logic       issue_ready,
    input  logic [5:0] issue_wfid,
    input  logic [2:0] issue_src_rd_en,
    input  logic       issue_vgpr_wr_en,
    input  logic       issue_vcc_wr_en,
    input  logic       issue_sgpr_wr_en,
    output logic [2:0] rf_rd_en,
    output logic [1:0] rf_rd_pass,
    output logic       alu_valid,
    output logic [1:0] alu_pass,
    output logic       vgpr_wr_en,
    output logic       scalar_wb_req,
    input  logic       scalar_wb_grant,
    output logic       vcc_wr_en,
    output logic       sgpr_wr_en,
    output logic       done,
    output logic [5:0] done_wfid
);

    localparam int unsigned WFID_W = 6;
    localparam int unsigned SRC_W  = 3;
    localparam int unsigned PASS_W = 2;
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(3);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        SCALAR_WB,
        DONE
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [PASS_W-1:0]   pass_q;
    logic [PASS_W-1:0]   pass_d;
    logic                accept;
    logic [SRC_W-1:0]    src_q;
    logic [SRC_W-1:0]    src_d;
    logic [WFID_W-1:0]   wfid_q;
    logic                vgpr_q;
    logic                vcc_q;
    logic                sgpr_q;

    assign rf_rd_pass = pass_q;

    // Next state, pass counter and the grant-cycle scalar strobes
    always_comb begin
        state_d    = state_q;
        pass_d     = pass_q;
        accept     = 1'b0;
        src_d      = src_q;
        vcc_wr_en  = 1'b0;
        sgpr_wr_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue_valid) begin
                    accept  = 1'b1;
                    src_d   = issue_src_rd_en;
                    pass_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                pass_d = pass_q + PASS_W'(1);
                if (pass_q == LAST_PASS) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = (vcc_q || sgpr_q) ? SCALAR_WB : DONE;
            end
            SCALAR_WB: begin
                if (scalar_wb_grant) begin
                    vcc_wr_en  = vcc_q;
                    sgpr_wr_en = sgpr_q;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched instruction fields and registered strobes
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            pass_q        <= '0;
            src_q         <= '0;
            wfid_q        <= '0;
            vgpr_q        <= 1'b0;
            vcc_q         <= 1'b0;
            sgpr_q        <= 1'b0;
            issue_ready   <= 1'b1;
            rf_rd_en      <= '0;
            alu_valid     <= 1'b0;
            alu_pass      <= '0;
            vgpr_wr_en    <= 1'b0;
            scalar_wb_req <= 1'b0;
            done          <= 1'b0;
            done_wfid     <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            if (accept) begin
                src_q  <= issue_src_rd_en;
                wfid_q <= issue_wfid;
                vgpr_q <= issue_vgpr_wr_en;
                vcc_q  <= issue_vcc_wr_en;
                sgpr_q <= issue_sgpr_wr_en;
            end
            issue_ready   <= (state_d == IDLE);
            rf_rd_en      <= (state_d == RUN) ? src_d : '0;
            // ALU result trails the operand read of the same pass by one cycle
            alu_valid     <= (state_q == RUN);
            alu_pass      <= (state_q == RUN) ? pass_q : '0;
            vgpr_wr_en    <= (state_q == RUN) && vgpr_q;
            scalar_wb_req <= (state_d == SCALAR_WB);
            done          <= (state_d == DONE);
            done_wfid     <= (state_d == DONE) ? wfid_q : '0;
        end
    end

endmodule

// File: tb/tb_simd_pass_sequencer.sv
// Self-checking bench for simd_pass_sequencer: per-cycle timeline checks plus
// scoreboard queues for ALU pass results and completion wfids.
module tb_simd_pass_sequencer;

    logic       clk;
    logic       rst;
    logic       issue_valid;
    logic       issue_ready;
    logic [5:0] issue_wfid;
    logic [2:0] issue_src_rd_en;
    logic       issue_vgpr_wr_en;
    logic       issue_vcc_wr_en;
    logic       issue_sgpr_wr_en;
    logic [2:0] rf_rd_en;
    logic [1:0] rf_rd_pass;
    logic       alu_valid;
    logic [1:0] alu_pass;
    logic       vgpr_wr_en;
    logic       scalar_wb_req;
    logic       scalar_wb_grant;
    logic       vcc_wr_en;
    logic       sgpr_wr_en;
    logic       done;
    logic [5:0] done_wfid;

    int errors = 0;
    int checks = 0;

    logic [2:0] alu_q[$];   // {pass, vgpr_wr_en}
    logic [5:0] done_q[$];

    simd_pass_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .issue_valid      (issue_valid),
        .issue_ready      (issue_ready),
        .issue_wfid       (issue_wfid),
        .issue_src_rd_en  (issue_src_rd_en),
        .issue_vgpr_wr_en (issue_vgpr_wr_en),
        .issue_vcc_wr_en  (issue_vcc_wr_en),
        .issue_sgpr_wr_en (issue_sgpr_wr_en),
        .rf_rd_en         (rf_rd_en),
        .rf_rd_pass       (rf_rd_pass),
        .alu_valid        (alu_valid),
        .alu_pass         (alu_pass),
        .vgpr_wr_en       (vgpr_wr_en),
        .scalar_wb_req    (scalar_wb_req),
        .scalar_wb_grant  (scalar_wb_grant),
        .vcc_wr_en        (vcc_wr_en),
        .sgpr_wr_en       (sgpr_wr_en),
        .done             (done),
        .done_wfid        (done_wfid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        issue_valid = 1'b0;
        scalar_wb_grant = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", issue_ready); end
        checks++;
        if ({rf_rd_en, rf_rd_pass, alu_valid, alu_pass, vgpr_wr_en} !== 9'd0) begin
            errors++; $display("FAIL reset_datapath got=%b exp=0", {rf_rd_en, rf_rd_pass, alu_valid, alu_pass, vgpr_wr_en});
        end
        checks++;
        if ({scalar_wb_req, vcc_wr_en, sgpr_wr_en, done, done_wfid} !== 10'd0) begin
            errors++; $display("FAIL reset_ctrl got=%b exp=0", {scalar_wb_req, vcc_wr_en, sgpr_wr_en, done, done_wfid});
        end
    endtask

    // Grant offered while idle must not produce scalar strobes
    task automatic test_grant_idle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            scalar_wb_grant = 1'b1;
            #1;
            checks++;
            if ({vcc_wr_en, sgpr_wr_en, scalar_wb_req} !== 3'b000) begin
                errors++; $display("FAIL grant_idle cyc=%0d got=%b exp=000", k, {vcc_wr_en, sgpr_wr_en, scalar_wb_req});
            end
        end
        scalar_wb_grant = 1'b0;
    endtask

    // Issue one instruction and check every cycle through completion
    task automatic test_instr(input string name, input logic [5:0] wf, input logic [2:0] src,
                              input logic v, input logic c, input logic s, input int gd,
                              input bit grant_always, input bit hold);
        int         wb_k;
        int         done_k;
        int         last_k;
        bit         ws;
        logic [2:0] e_rd;
        logic [2:0] got;
        logic [5:0] ewf;
        ws     = c | s;
        wb_k   = 6 + gd;
        done_k = ws ? wb_k + 1 : 6;
        last_k = hold ? done_k : done_k + 1;
        @(negedge clk);
        issue_wfid       = wf;
        issue_src_rd_en  = src;
        issue_vgpr_wr_en = v;
        issue_vcc_wr_en  = c;
        issue_sgpr_wr_en = s;
        issue_valid      = 1'b1;
        scalar_wb_grant  = grant_always;
        #1;
        checks++;
        if (issue_ready !== 1'b1) begin errors++; $display("FAIL %s issue_ready T got=%b exp=1", name, issue_ready); end
        for (int p = 0; p < 4; p++) alu_q.push_back({2'(p), v});
        done_q.push_back(wf);
        for (int k = 1; k <= last_k; k++) begin
            @(negedge clk);
            if (!hold) issue_valid = 1'b0;
            scalar_wb_grant = grant_always || (ws && k >= wb_k);
            #1;
            e_rd = (k >= 1 && k <= 4) ? src : 3'b000;
            checks++;
            if (rf_rd_en !== e_rd) begin errors++; $display("FAIL %s rf_rd_en T+%0d got=%b exp=%b", name, k, rf_rd_en, e_rd); end
            checks++;
            if (rf_rd_pass !== ((k >= 1 && k <= 4) ? 2'(k - 1) : 2'd0)) begin
                errors++; $display("FAIL %s rf_rd_pass T+%0d got=%0d", name, k, rf_rd_pass);
            end
            checks++;
            if (alu_valid !== (k >= 2 && k <= 5)) begin
                errors++; $display("FAIL %s alu_valid T+%0d got=%b exp=%b", name, k, alu_valid, (k >= 2 && k <= 5));
            end
            if (alu_valid === 1'b1) begin
                checks++;
                if (alu_q.size() == 0) begin
                    errors++; $display("FAIL %s alu_unexpected T+%0d got=pass%0d exp=none", name, k, alu_pass);
                end else begin
                    got = alu_q.pop_front();
                    if ({alu_pass, vgpr_wr_en} !== got) begin
                        errors++; $display("FAIL %s alu_pass_vgpr T+%0d got=%b exp=%b", name, k, {alu_pass, vgpr_wr_en}, got);
                    end
                end
            end else begin
                checks++;
                if (vgpr_wr_en !== 1'b0) begin errors++; $display("FAIL %s vgpr_wr_en_idle T+%0d got=%b exp=0", name, k, vgpr_wr_en); end
            end
            checks++;
            if (scalar_wb_req !== (ws && k >= 6 && k <= wb_k)) begin
                errors++; $display("FAIL %s scalar_wb_req T+%0d got=%b exp=%b", name, k, scalar_wb_req, (ws && k >= 6 && k <= wb_k));
            end
            checks++;
            if ({vcc_wr_en, sgpr_wr_en} !== {ws && k == wb_k && c, ws && k == wb_k && s}) begin
                errors++; $display("FAIL %s vcc_sgpr T+%0d got=%b%b exp=%b%b", name, k, vcc_wr_en, sgpr_wr_en,
                                   (ws && k == wb_k && c), (ws && k == wb_k && s));
            end
            checks++;
            if (done !== (k == done_k)) begin errors++; $display("FAIL %s done T+%0d got=%b exp=%b", name, k, done, (k == done_k)); end
            if (done === 1'b1) begin
                checks++;
                if (done_q.size() == 0) begin
                    errors++; $display("FAIL %s done_unexpected T+%0d got=%0d exp=none", name, k, done_wfid);
                end else begin
                    ewf = done_q.pop_front();
                    if (done_wfid !== ewf) begin errors++; $display("FAIL %s done_wfid T+%0d got=%0d exp=%0d", name, k, done_wfid, ewf); end
                end
            end
            checks++;
            if (issue_ready !== (k > done_k)) begin
                errors++; $display("FAIL %s issue_ready T+%0d got=%b exp=%b", name, k, issue_ready, (k > done_k));
            end
        end
        if (!hold) scalar_wb_grant = 1'b0;
    endtask

    // issue_valid held high: the second accept lands the cycle after DONE
    task automatic test_back_to_back();
        test_instr("b2b_first", 6'd17, 3'b101, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        test_instr("b2b_second", 6'd42, 3'b110, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0);
    endtask

    // Synchronous reset during RUN aborts with no further strobes
    task automatic test_reset_mid();
        @(negedge clk);
        issue_wfid       = 6'd9;
        issue_src_rd_en  = 3'b111;
        issue_vgpr_wr_en = 1'b1;
        issue_vcc_wr_en  = 1'b1;
        issue_sgpr_wr_en = 1'b1;
        issue_valid      = 1'b1;
        scalar_wb_grant  = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            issue_valid = 1'b0;
            if (k == 3) rst = 1'b0;
            #1;
            checks++;
            if (rf_rd_en !== 3'b111) begin errors++; $display("FAIL rst_mid pre rf_rd_en T+%0d got=%b exp=111", k, rf_rd_en); end
        end
        for (int k = 4; k <= 12; k++) begin
            @(negedge clk);
            rst = 1'b1;
            #1;
            checks++;
            if ({rf_rd_en, alu_valid, vgpr_wr_en, scalar_wb_req, vcc_wr_en, sgpr_wr_en, done} !== 9'd0) begin
                errors++; $display("FAIL rst_mid strobes T+%0d got=%b exp=0", k,
                                   {rf_rd_en, alu_valid, vgpr_wr_en, scalar_wb_req, vcc_wr_en, sgpr_wr_en, done});
            end
            checks++;
            if (issue_ready !== 1'b1) begin errors++; $display("FAIL rst_mid issue_ready T+%0d got=%b exp=1", k, issue_ready); end
        end
        scalar_wb_grant = 1'b0;
    endtask

    initial begin
        rst              = 1'b0;
        issue_valid      = 1'b0;
        issue_wfid       = '0;
        issue_src_rd_en  = '0;
        issue_vgpr_wr_en = 1'b0;
        issue_vcc_wr_en  = 1'b0;
        issue_sgpr_wr_en = 1'b0;
        scalar_wb_grant  = 1'b0;
        test_reset();
        test_grant_idle();
        test_instr("vop2_add", 6'd3, 3'b011, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0);
        test_instr("vop1_mov", 6'd5, 3'b001, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        test_instr("vop3_cmp", 6'd33, 3'b011, 1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b0);
        test_instr("both_scalar", 6'd63, 3'b111, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0);
        test_back_to_back();
        test_reset_mid();
        alu_q.delete();
        done_q.delete();
        test_instr("after_reset", 6'd12, 3'b100, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0);
        checks++;
        if (alu_q.size() != 0 || done_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover got=alu%0d/done%0d exp=0/0", alu_q.size(), done_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
